// File: rtl/call_stack.sv
// Return-address stack: pushes PC on call, returns saved PC + 1 on rtrn, supports call+rtrn top replacement.
// Optional circular (overwrite-oldest) behaviour when CALL_STACK_WRAP_EN is defined.

`ifndef POS_EDGE
`define POS_EDGE 1'b1
`endif
`ifndef NEG_EDGE
`define NEG_EDGE 1'b0
`endif

module call_stack #(
    parameter int unsigned addr_width  = 4,
    parameter int unsigned data_width  = 16,
    parameter bit          active_edge = `POS_EDGE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] i_PC,
    input  logic                  call,
    input  logic                  rtrn,
    input  logic                  err_clr,
    output logic [data_width-1:0] o_Stack,
    output logic                  o_valid,
    output logic [addr_width:0]   o_depth,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_ovf,
    output logic                  o_unf
);

    localparam int unsigned DEPTH = 2 ** addr_width;
    localparam int unsigned DW    = addr_width + 1;
`ifdef CALL_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [data_width-1:0] mem [DEPTH];
    logic [addr_width-1:0] sp;
    logic [addr_width-1:0] sp_top;
    logic [addr_width:0]   depth;
    logic                  clk_act;
    logic                  full_s;
    logic                  empty_s;
    logic                  pop_en;
    logic                  pop_only;
    logic                  replace;
    logic                  push_en;
    logic                  set_ovf;
    logic                  set_unf;
    logic [addr_width-1:0] wr_addr;

    // Negative-edge instances run off the inverted clock so one register description serves both.
    assign clk_act = active_edge ? clk : ~clk;

    assign sp_top  = sp - addr_width'(1);
    assign full_s  = (depth == DW'(DEPTH));
    assign empty_s = (depth == DW'(0));

    // Operation decode; a call+rtrn on an empty stack degrades to a plain push.
    always_comb begin
        pop_en   = rtrn && !empty_s;
        replace  = call && rtrn && !empty_s;
        pop_only = rtrn && !call && !empty_s;
        push_en  = call && !replace && (!full_s || WRAP);
        set_ovf  = call && !rtrn && full_s;
        set_unf  = rtrn && empty_s;
        wr_addr  = replace ? sp_top : sp;
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk_act) begin
        if (push_en || replace) begin
            mem[wr_addr] <= i_PC;
        end
    end

    always_ff @(posedge clk_act or negedge rst) begin
        if (!rst) begin
            sp      <= '0;
            depth   <= '0;
            o_Stack <= '0;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
            o_unf   <= 1'b0;
        end else begin
            o_valid <= pop_en;
            if (pop_en) begin
                o_Stack <= mem[sp_top] + data_width'(1);
            end
            if (push_en) begin
                sp <= sp + addr_width'(1);
            end else if (pop_only) begin
                sp <= sp_top;
            end
            if (push_en && !full_s) begin
                depth <= depth + DW'(1);
            end else if (pop_only) begin
                depth <= depth - DW'(1);
            end
            // A new error wins over a clear on the same edge.
            if (set_ovf) begin
                o_ovf <= 1'b1;
            end else if (err_clr) begin
                o_ovf <= 1'b0;
            end
            if (set_unf) begin
                o_unf <= 1'b1;
            end else if (err_clr) begin
                o_unf <= 1'b0;
            end
        end
    end

    assign o_depth = depth;
    assign o_full  = full_s;
    assign o_empty = empty_s;

endmodule
